alu_arbiter: RTL and testbench

//  Shares one alu instance between NUM_REQ independent requesters (e.g. decode-stage ALU ops, branch

---
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between NUM_REQ requesters. A round-robin arbiter grants a
//   single request in IDLE, the operands are registered, the ALU result is
//   captured in EXEC, and RESP holds the result until the owner accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high for the same index. reqReady is only raised for a requester
//   whose reqValid is high, and at most one bit at a time. rspValid holds
//   until the matching rspReady is seen. rspReady on other bits is ignored.
//
// Ports
//   clk        rising-edge clock
//   rstN       asynchronous active-low reset
//   reqValid   per-requester operation valid
//   reqReady   per-requester grant (combinational, IDLE only)
//   reqA/reqB  per-requester 32-bit operands, slice [32*i +: 32]
//   reqOp      per-requester ALU opcode, slice [3*i +: 3]
//   rspValid   one-hot result valid for the granted requester
//   rspReady   per-requester result accept
//   rspResult  registered ALU result
//   rspZero    registered zero flag
//   busy       high whenever the FSM is not IDLE
//   opCount    completed response handshakes, wraps
//   dbgState   current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic [NUM_REQ-1:0]     reqValid,
   output logic [NUM_REQ-1:0]     reqReady,
   input  logic [NUM_REQ*32-1:0]  reqA,
   input  logic [NUM_REQ*32-1:0]  reqB,
   input  logic [NUM_REQ*3-1:0]   reqOp,
   output logic [NUM_REQ-1:0]     rspValid,
   input  logic [NUM_REQ-1:0]     rspReady,
   output logic [31:0]            rspResult,
   output logic                   rspZero,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   opCount,
   output logic [1:0]             dbgState
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0]     gnt_q;
   logic [31:0]          opA_q, opB_q;
   logic [2:0]           op_q;
   logic [31:0]          result_q;
   logic                 zero_q;
   logic [CNT_WIDTH-1:0] opCount_q, opCount_d;

   logic                 anyValid;
   logic                 found;
   logic [IDX_W-1:0]     winIdx;
   logic [IDX_W:0]       candSum;
   logic [IDX_W-1:0]     cand;
   logic [31:0]          selA, selB;
   logic [2:0]           selOp;
   logic [31:0]          aluResult;
   logic                 grant;
   logic                 rspDone;

   // Round-robin scan: first valid requester at or above rrPtr, wrapping.
   always_comb begin
      anyValid = |reqValid;
      found    = 1'b0;
      winIdx   = '0;
      candSum  = '0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         candSum = {1'b0, rrPtr_q} + (IDX_W+1)'(k);
         if (candSum >= (IDX_W+1)'(NUM_REQ)) begin
            candSum = candSum - (IDX_W+1)'(NUM_REQ);
         end
         cand = candSum[IDX_W-1:0];
         if (!found && reqValid[cand]) begin
            found  = 1'b1;
            winIdx = cand;
         end
      end
   end

   // Operand mux for the winner.
   always_comb begin
      selA  = '0;
      selB  = '0;
      selOp = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winIdx == IDX_W'(k)) begin
            selA  = reqA[32*k +: 32];
            selB  = reqB[32*k +: 32];
            selOp = reqOp[3*k +: 3];
         end
      end
   end

   // ALU on the registered operands; SLT is an unsigned compare.
   always_comb begin
      case (op_q)
         3'b000:  aluResult = opA_q + opB_q;
         3'b001:  aluResult = opA_q - opB_q;
         3'b010:  aluResult = opA_q & opB_q;
         3'b011:  aluResult = opA_q | opB_q;
         3'b100:  aluResult = opA_q ^ opB_q;
         3'b101:  aluResult = (opA_q < opB_q) ? 32'd1 : 32'd0;
         default: aluResult = 32'd0;
      endcase
   end

   assign grant   = (state_q == IDLE) && anyValid;
   assign rspDone = (state_q == RESP) && rspReady[gnt_q];

   assign rrPtr_d   = grant ? ((winIdx == IDX_W'(NUM_REQ-1)) ? '0 : winIdx + IDX_W'(1))
                            : rrPtr_q;
   assign opCount_d = rspDone ? opCount_q + CNT_WIDTH'(1) : opCount_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (anyValid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rspReady[gnt_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. reqReady is also gated by rstN so no grant is offered while
   // reset is held, even though the state already reads IDLE.
   always_comb begin
      reqReady = '0;
      rspValid = '0;
      busy     = (state_q != IDLE);
      dbgState = state_q;
      if (rstN && grant) begin
         reqReady[winIdx] = 1'b1;
      end
      if (state_q == RESP) begin
         rspValid[gnt_q] = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rrPtr_q   <= '0;
         gnt_q     <= '0;
         opA_q     <= '0;
         opB_q     <= '0;
         op_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         opCount_q <= '0;
      end else begin
         rrPtr_q   <= rrPtr_d;
         opCount_q <= opCount_d;
         if (grant) begin
            gnt_q <= winIdx;
            opA_q <= selA;
            opB_q <= selB;
            op_q  <= selOp;
         end
         if (state_q == EXEC) begin
            result_q <= aluResult;
            zero_q   <= (aluResult == 32'd0);
         end
      end
   end

   assign rspResult = result_q;
   assign rspZero   = zero_q;
   assign opCount   = opCount_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  reqValid, reqReady, rspValid, rspReady;
   logic [63:0] reqA, reqB;
   logic [5:0]  reqOp;
   logic [31:0] rspResult;
   logic        rspZero, busy;
   logic [15:0] opCount;
   logic [1:0]  dbgState;
   // Second instance with a 2-bit counter, sharing all inputs.
   logic [1:0]  reqReady2, rspValid2, opCount2, dbgState2;
   logic [31:0] rspResult2;
   logic        rspZero2, busy2;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;
   logic [32:0] exp_q[$];
   int          exp_idx_q[$];

   alu_arbiter #(.NUM_REQ(2), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady),
      .reqA(reqA), .reqB(reqB), .reqOp(reqOp), .rspValid(rspValid),
      .rspReady(rspReady), .rspResult(rspResult), .rspZero(rspZero),
      .busy(busy), .opCount(opCount), .dbgState(dbgState));

   alu_arbiter #(.NUM_REQ(2), .CNT_WIDTH(2)) u_dut_c2 (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady2),
      .reqA(reqA), .reqB(reqB), .reqOp(reqOp), .rspValid(rspValid2),
      .rspReady(rspReady), .rspResult(rspResult2), .rspZero(rspZero2),
      .busy(busy2), .opCount(opCount2), .dbgState(dbgState2));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
      logic [31:0] r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (a < b) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstN     = 1'b0;
      rspReady = '0;
      exp_q.delete();
      exp_idx_q.delete();
      exp_count = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
      reqA[32*idx +: 32] = a;
      reqB[32*idx +: 32] = b;
      reqOp[3*idx +: 3]  = op;
      reqValid[idx]      = 1'b1;
   endtask

   // Waits for any grant; pushes the expected result of exp_idx's operands.
   task automatic wait_grant(input int exp_idx, output bit ok);
      ok = 1'b0;
      #1;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (reqReady != 2'b00) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         exp_q.push_back(alu_model(reqA[32*exp_idx +: 32], reqB[32*exp_idx +: 32],
                                   reqOp[3*exp_idx +: 3]));
         exp_idx_q.push_back(exp_idx);
      end
   endtask

   // Called just after the request handshake edge; lat counts negedges waited.
   task automatic wait_rsp(output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         lat++;
         if (rspValid != 2'b00) ok = 1'b1;
      end
   endtask

   task automatic pop_exp(output logic [32:0] e, output int ei);
      if (exp_q.size() == 0) begin
         e  = 'x;
         ei = -1;
      end else begin
         e  = exp_q.pop_front();
         ei = exp_idx_q.pop_front();
      end
   endtask

   task automatic accept(input int idx);
      rspReady      = '0;
      rspReady[idx] = 1'b1;
      step();
      rspReady  = '0;
      exp_count = exp_count + 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reqValid = 2'b01;
      set_req(0, 32'd1, 32'd2, 3'd0);
      rstN = 1'b0;
      rspReady = '0;
      exp_count = 0;
      #3;
      checks++;
      if ({reqReady, rspValid, busy, dbgState} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rr=%b rv=%b busy=%b st=%0d want all 0",
                  reqReady, rspValid, busy, dbgState);
      end
      checks++;
      if ({rspZero, rspResult, opCount} !== 49'b0) begin
         errors++;
         $display("FAIL reset_data got res=%h z=%b cnt=%0d want 0", rspResult, rspZero, opCount);
      end
      reqValid = '0;
      do_reset();
   endtask

   task automatic test_single();
      bit ok; int lat; logic [32:0] e; int ei;
      set_req(0, 32'd5, 32'd3, 3'd0);
      wait_grant(0, ok);
      checks++;
      if (!ok || reqReady !== 2'b01) begin
         errors++; $display("FAIL t1_grant got %b want 01", reqReady);
      end
      step();
      reqValid = '0;
      wait_rsp(ok, lat);
      pop_exp(e, ei);
      checks++;
      if (!ok || lat != 2 || rspValid !== 2'b01) begin
         errors++; $display("FAIL t1_latency got lat=%0d rv=%b want lat=2 rv=01", lat, rspValid);
      end
      checks++;
      if ({rspZero, rspResult} !== e || rspResult !== 32'd8) begin
         errors++; $display("FAIL t1_result got %h z=%b want 8 z=0", rspResult, rspZero);
      end
      accept(0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || opCount !== 16'(exp_count) || rspValid !== 2'b00) begin
         errors++;
         $display("FAIL t1_done got busy=%b cnt=%0d rv=%b want busy=0 cnt=%0d rv=00",
                  busy, opCount, rspValid, exp_count);
      end
   endtask

   task automatic test_priority();
      bit ok; int lat; logic [32:0] e; int ei;
      rstN = 1'b0;
      set_req(0, 32'd7, 32'd7, 3'd1);
      set_req(1, 32'd1, 32'd2, 3'd5);
      do_reset();
      for (int n = 0; n < 2; n++) begin
         wait_grant(n, ok);
         checks++;
         if (!ok || reqReady !== (2'b01 << n)) begin
            errors++; $display("FAIL t2_grant%0d got %b want %b", n, reqReady, 2'b01 << n);
         end
         step();
         reqValid[n] = 1'b0;
         wait_rsp(ok, lat);
         pop_exp(e, ei);
         checks++;
         if (!ok || rspValid !== (2'b01 << ei) || {rspZero, rspResult} !== e) begin
            errors++;
            $display("FAIL t2_rsp%0d got rv=%b res=%h z=%b want rv=%b res=%h z=%b",
                     n, rspValid, rspResult, rspZero, 2'b01 << ei, e[31:0], e[32]);
         end
         accept(ei);
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int lat; logic [32:0] e; int ei;
      do_reset();
      set_req(0, 32'd10, 32'd3, 3'd0);
      set_req(1, 32'd10, 32'd3, 3'd1);
      for (int i = 0; i < 6; i++) begin
         wait_grant(i % 2, ok);
         checks++;
         if (!ok || reqReady !== (2'b01 << (i % 2))) begin
            errors++; $display("FAIL t3_rr%0d got %b want %b", i, reqReady, 2'b01 << (i % 2));
         end
         step();
         wait_rsp(ok, lat);
         pop_exp(e, ei);
         checks++;
         if (!ok || rspValid !== (2'b01 << ei) || {rspZero, rspResult} !== e) begin
            errors++;
            $display("FAIL t3_rsp%0d got rv=%b res=%h want rv=%b res=%h",
                     i, rspValid, rspResult, 2'b01 << ei, e[31:0]);
         end
         accept(ei);
      end
      reqValid = '0;
   endtask

   task automatic test_stall();
      bit ok; int lat; logic [32:0] e; int ei; int bad;
      set_req(1, $urandom, $urandom, 3'($urandom_range(0, 5)));
      wait_grant(1, ok);
      step();
      set_req(0, 32'd4, 32'd6, 3'd3);
      wait_rsp(ok, lat);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (rspValid !== 2'b10 || {rspZero, rspResult} !== exp_q[0] ||
             reqReady !== 2'b00 || busy !== 1'b1) bad++;
         rspReady = 2'b01;  // non-granted bit must be ignored
         @(negedge clk);
      end
      rspReady = '0;
      checks++;
      if (!ok || bad != 0) begin
         errors++; $display("FAIL t4_hold got %0d bad cycles want 0", bad);
      end
      pop_exp(e, ei);
      accept(ei);
      reqValid[1] = 1'b0;
      wait_grant(0, ok);
      checks++;
      if (!ok || reqReady !== 2'b01) begin
         errors++; $display("FAIL t4_next_grant got %b want 01", reqReady);
      end
      step();
      reqValid = '0;
      wait_rsp(ok, lat);
      pop_exp(e, ei);
      checks++;
      if (!ok || {rspZero, rspResult} !== e) begin
         errors++; $display("FAIL t4_next_rsp got %h want %h", rspResult, e[31:0]);
      end
      accept(ei);
      @(negedge clk);
      checks++;
      if (opCount !== 16'(exp_count)) begin
         errors++; $display("FAIL t4_count got %0d want %0d", opCount, exp_count);
      end
   endtask

   task automatic test_reset_exec();
      bit ok; int lat; logic [32:0] e; int ei; int seen;
      set_req(0, 32'd9, 32'd9, 3'd0);
      wait_grant(0, ok);
      step();
      reqValid = '0;
      #2;
      rstN = 1'b0;
      #1;
      checks++;
      if ({reqReady, rspValid, busy, dbgState, rspZero, rspResult, opCount} !== 55'b0) begin
         errors++;
         $display("FAIL t5_async got rv=%b busy=%b st=%0d res=%h cnt=%0d want all 0",
                  rspValid, busy, dbgState, rspResult, opCount);
      end
      exp_q.delete();
      exp_idx_q.delete();
      exp_count = 0;
      @(negedge clk);
      rstN = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rspValid !== 2'b00 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL t5_dropped got %0d cycles with rsp want 0", seen);
      end
      set_req(1, 32'd100, 32'd58, 3'd1);
      wait_grant(1, ok);
      step();
      reqValid = '0;
      wait_rsp(ok, lat);
      pop_exp(e, ei);
      checks++;
      if (!ok || rspValid !== 2'b10 || {rspZero, rspResult} !== e || rspResult !== 32'd42) begin
         errors++; $display("FAIL t5_after got rv=%b res=%0d want rv=10 res=42", rspValid, rspResult);
      end
      accept(ei);
      @(negedge clk);
      checks++;
      if (opCount !== 16'd1) begin
         errors++; $display("FAIL t5_count got %0d want 1", opCount);
      end
   endtask

   task automatic test_ops_wrap();
      bit ok; int lat; logic [32:0] e; int ei;
      logic [2:0]  t_op[9];
      logic [31:0] t_a[9];
      logic [31:0] t_b[9];
      t_op = '{3'd6, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5};
      t_a  = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'hF0F0F0F0,
               32'h12340000, 32'hA5A5A5A5, 32'd12, 32'd3};
      t_b  = '{32'd1, 32'd1, 32'd2, 32'd1, 32'h0FF00FF0,
               32'h00005678, 32'hA5A5A5A5, 32'd34, 32'h80000000};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_req(i % 2, t_a[i], t_b[i], t_op[i]);
         wait_grant(i % 2, ok);
         step();
         reqValid = '0;
         wait_rsp(ok, lat);
         pop_exp(e, ei);
         checks++;
         if (!ok || rspValid !== (2'b01 << ei) || {rspZero, rspResult} !== e) begin
            errors++;
            $display("FAIL t6_op%0d got res=%h z=%b want res=%h z=%b",
                     i, rspResult, rspZero, e[31:0], e[32]);
         end
         accept(ei);
         if (i == 4) begin
            @(negedge clk);
            checks++;
            if (opCount !== 16'd5 || opCount2 !== 2'd1) begin
               errors++; $display("FAIL t6_wrap got %0d/%0d want 5/1", opCount, opCount2);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (opCount !== 16'(exp_count) || opCount2 !== 2'(exp_count)) begin
         errors++;
         $display("FAIL t6_count got %0d/%0d want %0d/%0d",
                  opCount, opCount2, exp_count, exp_count % 4);
      end
   endtask

   initial begin
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
      reqOp    = '0;
      rspReady = '0;
      rstN     = 1'b1;
      test_reset();
      test_single();
      test_priority();
      test_back_to_back();
      test_stall();
      test_reset_exec();
      test_ops_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
